// File: rtl/ecb_ctrl_pkg.sv
// Shared constants for the bit-serial ECB controller: FSM encodings,
// default block width and completed-block counter width.
package ecb_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int unsigned BLOCK_W_DEFAULT = 8;
    localparam int unsigned BLK_CNT_W       = 16;

endpackage

// File: rtl/ebc_enc_1bit.sv
// One-bit XOR encryption cell used as the serial datapath of ecb_serial_ctrl.
module ebc_enc_1bit (
    input  logic K,
    input  logic PT,
    output logic CT
);

    assign CT = PT ^ K;

endmodule

// File: rtl/ecb_serial_ctrl.sv
// Bit-serial ECB sequencer: accepts a block/key, streams LSB-first through
// ebc_enc_1bit, presents the ciphertext. Optional macro: ECB_BLK_CNT_EN.
module ecb_serial_ctrl
    import ecb_ctrl_pkg::*;
#(
    parameter int unsigned BLOCK_W = BLOCK_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_pt,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_ct,
    output logic               busy
`ifdef ECB_BLK_CNT_EN
    ,
    output logic [BLK_CNT_W-1:0] blk_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BLOCK_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_W - 1);

    logic [1:0]         state;
    logic [BLOCK_W-1:0] pt_sr;
    logic [BLOCK_W-1:0] key_sr;
    logic [BLOCK_W-1:0] ct_sr;
    logic [CNT_W-1:0]   cnt;
    logic               ct_bit;

    ebc_enc_1bit u_enc (
        .K  (key_sr[0]),
        .PT (pt_sr[0]),
        .CT (ct_bit)
    );

    // Counter holds at CNT_LAST on the exit edge so it never wraps inside a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pt_sr  <= '0;
            key_sr <= '0;
            ct_sr  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pt_sr  <= in_pt;
                        key_sr <= in_key;
                        ct_sr  <= '0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ct_sr  <= {ct_bit, ct_sr[BLOCK_W-1:1]};
                    pt_sr  <= pt_sr >> 1;
                    key_sr <= key_sr >> 1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ECB_BLK_CNT_EN
    logic [BLK_CNT_W-1:0] blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else if (state == ST_DONE && out_ready) begin
            blk_q <= blk_q + BLK_CNT_W'(1);
        end
    end

    assign blk_cnt = blk_q;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign out_ct    = ct_sr;

endmodule

// File: tb/tb_ecb_serial_ctrl.sv
// Directed scoreboard bench for ecb_serial_ctrl at BLOCK_W = 8, 2 and 32
// (blk_cnt checks only when ECB_BLK_CNT_EN is defined).
module tb_ecb_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v     [3];
    logic        ordy  [3];
    logic [63:0] pt_in [3];
    logic [63:0] key_in[3];

    logic        ir8, ov8, busy8;
    logic [7:0]  ct8;
    logic        ir2, ov2, busy2;
    logic [1:0]  ct2;
    logic        ir32, ov32, busy32;
    logic [31:0] ct32;
`ifdef ECB_BLK_CNT_EN
    logic [15:0] blk8, blk2, blk32;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_acc[3];
    int prev_acc[3];
    int acc_cnt [3];
    int done_cnt[3];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    ecb_serial_ctrl #(.BLOCK_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(ir8),
        .in_pt(pt_in[0][7:0]), .in_key(key_in[0][7:0]), .out_valid(ov8),
        .out_ready(ordy[0]), .out_ct(ct8), .busy(busy8)
`ifdef ECB_BLK_CNT_EN
        , .blk_cnt(blk8)
`endif
    );

    ecb_serial_ctrl #(.BLOCK_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(ir2),
        .in_pt(pt_in[1][1:0]), .in_key(key_in[1][1:0]), .out_valid(ov2),
        .out_ready(ordy[1]), .out_ct(ct2), .busy(busy2)
`ifdef ECB_BLK_CNT_EN
        , .blk_cnt(blk2)
`endif
    );

    ecb_serial_ctrl #(.BLOCK_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(ir32),
        .in_pt(pt_in[2][31:0]), .in_key(key_in[2][31:0]), .out_valid(ov32),
        .out_ready(ordy[2]), .out_ct(ct32), .busy(busy32)
`ifdef ECB_BLK_CNT_EN
        , .blk_cnt(blk32)
`endif
    );

    function automatic int w_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 2 : 32;
    endfunction

    function automatic logic [63:0] msk(input int s);
        return (64'd1 << w_of(s)) - 64'd1;
    endfunction

    function automatic logic ir_of(input int s);
        return (s == 0) ? ir8 : (s == 1) ? ir2 : ir32;
    endfunction

    function automatic logic ov_of(input int s);
        return (s == 0) ? ov8 : (s == 1) ? ov2 : ov32;
    endfunction

    function automatic logic busy_of(input int s);
        return (s == 0) ? busy8 : (s == 1) ? busy2 : busy32;
    endfunction

    function automatic logic [63:0] ct_of(input int s);
        return (s == 0) ? {56'd0, ct8} : (s == 1) ? {62'd0, ct2} : {32'd0, ct32};
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [63:0] e);
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int s, output logic [63:0] e);
        case (s)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); q2.delete();
        for (int s = 0; s < 3; s++) done_cnt[s] = 0;
    endtask

    // Called at a negedge: predicts the coming posedge, advances to the next negedge.
    task automatic step();
        logic acc[3];
        logic hs [3];
        logic [63:0] e;
        for (int s = 0; s < 3; s++) begin
            acc[s] = rst_n && v[s] && ir_of(s);
            hs[s]  = rst_n && ov_of(s) && ordy[s];
            if (acc[s]) push(s, (pt_in[s] ^ key_in[s]) & msk(s));
            if (hs[s]) begin
                chk($sformatf("sb_nonempty%0d", s), (qsize(s) != 0) ? 64'd1 : 64'd0, 64'd1);
                if (qsize(s) != 0) begin
                    pop(s, e);
                    chk($sformatf("ct_sb%0d", s), ct_of(s), e);
                end
                done_cnt[s]++;
            end
        end
        @(posedge clk);
        cyc++;
        for (int s = 0; s < 3; s++) begin
            if (acc[s]) begin
                prev_acc[s] = last_acc[s];
                last_acc[s] = cyc;
                acc_cnt[s]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_ov(input int s, input int budget, output int lat);
        for (int i = 0; i < budget; i++) begin
            if (ov_of(s)) break;
            step();
        end
        chk($sformatf("ov_seen%0d", s), {63'd0, ov_of(s)}, 64'd1);
        lat = cyc - last_acc[s];
    endtask

    task automatic send(input int s, input logic [63:0] pt, input logic [63:0] key);
        v[s] = 1'b1; pt_in[s] = pt; key_in[s] = key;
        step();
        v[s] = 1'b0;
    endtask

    initial begin
        int lat;
        int a0, d0;
        for (int s = 0; s < 3; s++) begin
            v[s] = 1'b0; ordy[s] = 1'b0; pt_in[s] = '0; key_in[s] = '0;
            last_acc[s] = 0; prev_acc[s] = 0; acc_cnt[s] = 0; done_cnt[s] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_in_ready%0d", s), {63'd0, ir_of(s)}, 64'd1);
            chk($sformatf("rst_out_valid%0d", s), {63'd0, ov_of(s)}, 64'd0);
            chk($sformatf("rst_out_ct%0d", s), ct_of(s), 64'd0);
            chk($sformatf("rst_busy%0d", s), {63'd0, busy_of(s)}, 64'd0);
        end
`ifdef ECB_BLK_CNT_EN
        chk("rst_blk_cnt", {48'd0, blk8}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic block: out_valid W edges after accept (cycle W+1), IDLE one edge later.
        ordy[0] = 1'b1;
        send(0, 64'hA5, 64'h3C);
        chk("basic_in_ready_drop", {63'd0, ir8}, 64'd0);
        chk("basic_busy", {63'd0, busy8}, 64'd1);
        wait_ov(0, 20, lat);
        chk("basic_latency", 64'(lat), 64'd8);
        chk("basic_ct", {56'd0, ct8}, 64'h99);
        step();
        chk("basic_in_ready_back", {63'd0, ir8}, 64'd1);
        chk("basic_idle_edge", 64'(cyc - last_acc[0]), 64'd9);
        chk("basic_q_empty", 64'(qsize(0)), 64'd0);

        // Back-to-back with in_valid held high.
        a0 = acc_cnt[0]; d0 = done_cnt[0];
        v[0] = 1'b1; pt_in[0] = 64'hFF; key_in[0] = 64'hFF;
        step();
        pt_in[0] = 64'h00; key_in[0] = 64'h5A;
        for (int i = 0; i < 40 && acc_cnt[0] < a0 + 2; i++) step();
        v[0] = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt[0] - a0), 64'd2);
        chk("b2b_period", 64'(last_acc[0] - prev_acc[0]), 64'd10);
        for (int i = 0; i < 40 && done_cnt[0] < d0 + 2; i++) step();
        chk("b2b_done", 64'(done_cnt[0] - d0), 64'd2);
        chk("b2b_q_empty", 64'(qsize(0)), 64'd0);

        // Backpressure: DONE holds, in_valid ignored.
        a0 = acc_cnt[0];
        ordy[0] = 1'b0;
        send(0, 64'hC3, 64'h96);
        wait_ov(0, 20, lat);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", {63'd0, ov8}, 64'd1);
            chk("bp_out_ct", {56'd0, ct8}, 64'h55);
            chk("bp_in_ready", {63'd0, ir8}, 64'd0);
            v[0] = i[0]; pt_in[0] = 64'(i); key_in[0] = 64'hE7;
            step();
        end
        v[0] = 1'b0; ordy[0] = 1'b1;
        step();
        chk("bp_single_accept", 64'(acc_cnt[0] - a0), 64'd1);
        chk("bp_in_ready_back", {63'd0, ir8}, 64'd1);
        chk("bp_q_empty", 64'(qsize(0)), 64'd0);

        // Reset during RUN (cycle 4 of the block).
        send(0, 64'hFF, 64'h00);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, ir8}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("mid_rst_out_ct", {56'd0, ct8}, 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 64'h0F, 64'hF0);
        wait_ov(0, 20, lat);
        chk("post_rst_ct", {56'd0, ct8}, 64'hFF);
        step();

        // BLOCK_W = 2.
        ordy[1] = 1'b1;
        send(1, 64'b10, 64'b11);
        wait_ov(1, 10, lat);
        chk("w2_latency", 64'(lat), 64'd2);
        chk("w2_ct", {62'd0, ct2}, 64'b01);
        step();
        chk("w2_q_empty", 64'(qsize(1)), 64'd0);

        // BLOCK_W = 32, random vectors through the scoreboard.
        ordy[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(2, 64'($urandom), 64'($urandom));
            wait_ov(2, 50, lat);
            chk("w32_latency", 64'(lat), 64'd32);
            step();
        end
        chk("w32_done", 64'(done_cnt[2]), 64'd4);
        chk("w32_q_empty", 64'(qsize(2)), 64'd0);

`ifdef ECB_BLK_CNT_EN
        for (int k = 0; k < 2; k++) begin
            send(0, 64'(k), 64'h81);
            wait_ov(0, 20, lat);
            step();
        end
        chk("blk_cnt_three", {48'd0, blk8}, 64'(done_cnt[0]));
        chk("blk_cnt_three_abs", {48'd0, blk8}, 64'd3);
        force dut8.blk_q = 16'hFFFF;
        @(negedge clk);
        release dut8.blk_q;
        send(0, 64'h12, 64'h34);
        wait_ov(0, 20, lat);
        step();
        chk("blk_cnt_wrap", {48'd0, blk8}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
